// File: rtl/move_collector.sv
// move_collector
//   Drains the per-square move FIFOs of the square-unit array and serialises
//   their packed 8-move words into one stream of valid 19-bit moves.
//   Invalid slots (bit 18 set) are dropped, and a saturating move count is
//   kept per board.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       one-cycle pulse: a new board is loaded, so begin a pass
//   gen_done    AND of all square-unit done outputs
//   fifo_empty  per-unit FIFO empty flags
//   unit_sel    unit being read; drives the external 64:1 read-data mux
//   rden        read enable for FIFO[unit_sel]
//   fifo_word   muxed FIFO output; slot k is bits [19k+18:19k]
//   mv_valid    mv_data holds a valid move
//   mv_data     move {invalid, promote, pawn, pawn2, ep, castle, capture, from, to}
//   mv_ready    consumer accept
//   move_count  moves emitted this pass (saturates at MAX_MOVES)
//   overflow    sticky: a valid move was dropped at MAX_MOVES
//   list_done   one-cycle pulse at the end of a pass
//   busy        high whenever the collector is not idle
module move_collector #(
    parameter int unsigned NUM_UNITS = 64,
    parameter int unsigned MAX_MOVES = 255,
    parameter int unsigned RD_LAT    = 1,
    localparam int unsigned SEL_W    = $clog2(NUM_UNITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 gen_done,
    input  logic [NUM_UNITS-1:0] fifo_empty,
    output logic [SEL_W-1:0]     unit_sel,
    output logic                 rden,
    input  logic [151:0]         fifo_word,
    output logic                 mv_valid,
    output logic [18:0]          mv_data,
    input  logic                 mv_ready,
    output logic [7:0]           move_count,
    output logic                 overflow,
    output logic                 list_done,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SCAN, ST_READ, ST_WAIT, ST_UNPACK, ST_CHECK
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   unit_sel_q, unit_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [2:0]         slot_q, slot_d;
    logic [7:0]         lat_q, lat_d;
    logic [7:0][18:0]   word_q, word_d;
    logic               rden_q, rden_d;
    logic               mv_valid_q, mv_valid_d;
    logic [18:0]        mv_data_q, mv_data_d;
    logic [7:0]         move_count_q, move_count_d;
    logic               overflow_q, overflow_d;
    logic               list_done_q, list_done_d;

    // Round-robin search, starting at ptr_q
    int unsigned        scan_idx;
    logic [SEL_W-1:0]   cand;
    logic               found;
    logic [SEL_W-1:0]   found_idx;

    always_comb begin
        scan_idx  = 0;
        cand      = '0;
        found     = 1'b0;
        found_idx = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            scan_idx = 32'(ptr_q) + i;
            if (scan_idx >= NUM_UNITS) begin
                scan_idx = scan_idx - NUM_UNITS;
            end
            cand = scan_idx[SEL_W-1:0];
            if (!found && !fifo_empty[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    logic [18:0] cur_slot;
    logic [18:0] nxt_slot;
    logic        slot_done;
    logic [7:0]  count_n;

    always_comb begin
        state_d      = state_q;
        unit_sel_d   = unit_sel_q;
        ptr_d        = ptr_q;
        slot_d       = slot_q;
        lat_d        = lat_q;
        word_d       = word_q;
        rden_d       = 1'b0;
        mv_valid_d   = mv_valid_q;
        mv_data_d    = mv_data_q;
        move_count_d = move_count_q;
        overflow_d   = overflow_q;
        list_done_d  = 1'b0;
        cur_slot     = word_q[slot_q];
        nxt_slot     = word_q[slot_q - 3'd1];
        slot_done    = 1'b0;
        count_n      = move_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    move_count_d = '0;
                    overflow_d   = 1'b0;
                    ptr_d        = '0;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (found) begin
                    unit_sel_d = found_idx;
                    rden_d     = 1'b1;
                    state_d    = ST_READ;
                end else if (gen_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_READ: begin
                lat_d   = 8'(RD_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    word_d  = fifo_word;
                    slot_d  = 3'd7;
                    state_d = ST_UNPACK;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            ST_UNPACK: begin
                if (mv_valid_q) begin
                    if (mv_ready) begin
                        count_n      = move_count_q + 8'd1;
                        move_count_d = count_n;
                        mv_valid_d   = 1'b0;
                        slot_done    = 1'b1;
                    end
                end else if (cur_slot[18]) begin
                    slot_done = 1'b1;
                end else if (32'(move_count_q) >= MAX_MOVES) begin
                    overflow_d = 1'b1;
                    slot_done  = 1'b1;
                end else begin
                    mv_valid_d = 1'b1;
                    mv_data_d  = cur_slot;
                end
                // Finishing a slot also looks ahead to the next one, so that a
                // run of valid slots is presented back-to-back at one per cycle.
                if (slot_done) begin
                    if (slot_q == 3'd0) begin
                        ptr_d   = (32'(unit_sel_q) == NUM_UNITS - 1) ? '0 : unit_sel_q + 1'b1;
                        state_d = ST_SCAN;
                    end else begin
                        slot_d = slot_q - 3'd1;
                        if (!nxt_slot[18] && (32'(count_n) < MAX_MOVES)) begin
                            mv_valid_d = 1'b1;
                            mv_data_d  = nxt_slot;
                        end
                    end
                end
            end
            ST_CHECK: begin
                // gen_done can rise while words are still landing in the FIFOs
                if ((&fifo_empty) && gen_done) begin
                    list_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            unit_sel_q   <= '0;
            ptr_q        <= '0;
            slot_q       <= '0;
            lat_q        <= '0;
            word_q       <= '0;
            rden_q       <= 1'b0;
            mv_valid_q   <= 1'b0;
            mv_data_q    <= '0;
            move_count_q <= '0;
            overflow_q   <= 1'b0;
            list_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_sel_q   <= unit_sel_d;
            ptr_q        <= ptr_d;
            slot_q       <= slot_d;
            lat_q        <= lat_d;
            word_q       <= word_d;
            rden_q       <= rden_d;
            mv_valid_q   <= mv_valid_d;
            mv_data_q    <= mv_data_d;
            move_count_q <= move_count_d;
            overflow_q   <= overflow_d;
            list_done_q  <= list_done_d;
        end
    end

    assign unit_sel   = unit_sel_q;
    assign rden       = rden_q;
    assign mv_valid   = mv_valid_q;
    assign mv_data    = mv_data_q;
    assign move_count = move_count_q;
    assign overflow   = overflow_q;
    assign list_done  = list_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector
//   Directed bench for move_collector (instantiated with MAX_MOVES=4).
//   A small FIFO model stands in for the square-unit array, and a monitor
//   logs accepted moves, FIFO reads and list_done pulses.
module tb_move_collector;

    localparam logic [18:0] INV = 19'h40000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         gen_done;
    logic [63:0]  fifo_empty = '1;
    logic [5:0]   unit_sel;
    logic         rden;
    logic [151:0] fifo_word = '0;
    logic         mv_valid;
    logic [18:0]  mv_data;
    logic         mv_ready;
    logic [7:0]   move_count;
    logic         overflow;
    logic         list_done;
    logic         busy;

    always #5 clk = ~clk;

    move_collector #(
        .NUM_UNITS(64),
        .MAX_MOVES(4),
        .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .gen_done(gen_done),
        .fifo_empty(fifo_empty), .unit_sel(unit_sel), .rden(rden),
        .fifo_word(fifo_word), .mv_valid(mv_valid), .mv_data(mv_data),
        .mv_ready(mv_ready), .move_count(move_count), .overflow(overflow),
        .list_done(list_done), .busy(busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: 64 units x 4 words, one-cycle read latency
    logic [151:0] mem [64][4];
    int           cnt [64];
    logic         preq = 1'b0;
    logic [5:0]   pu   = '0;
    logic [151:0] pw   = '0;
    logic [5:0]   rd_log [64];
    int           rd_n = 0;

    always @(posedge clk) begin
        if (rden) begin
            fifo_word <= mem[unit_sel][0];
            for (int j = 0; j < 3; j++) mem[unit_sel][j] = mem[unit_sel][j+1];
            if (cnt[unit_sel] > 0) cnt[unit_sel] = cnt[unit_sel] - 1;
            if (rd_n < 64) rd_log[rd_n] = unit_sel;
            rd_n++;
        end
        if (preq && cnt[pu] < 4) begin
            mem[pu][cnt[pu]] = pw;
            cnt[pu] = cnt[pu] + 1;
        end
        for (int u = 0; u < 64; u++) fifo_empty[u] <= (cnt[u] == 0);
    end

    // Monitor: inputs change on negedge, DUT outputs on posedge
    logic [18:0] acc_log [64];
    int          acc_n = 0;
    int          ld_n  = 0;

    always begin
        @(negedge clk);
        #1;
        if (mv_valid && mv_ready) begin
            if (acc_n < 64) acc_log[acc_n] = mv_data;
            acc_n++;
        end
        if (list_done) ld_n++;
    end

    function automatic logic [18:0] mv(input logic [6:0] fl, input logic [5:0] fr, input logic [5:0] to);
        return {fl, fr, to};
    endfunction

    function automatic logic [151:0] word8(input logic [18:0] s7, s6, s5, s4, s3, s2, s1, s0);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic push(input logic [5:0] u, input logic [151:0] w);
        @(negedge clk);
        pu = u; pw = w; preq = 1'b1;
        @(negedge clk);
        preq = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ld(input int base, input string tag);
        int k;
        k = 0;
        while (ld_n == base && k < 500) begin
            @(posedge clk);
            k++;
        end
        check_eq({tag, "_done_seen"}, 32'(ld_n != base), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    int acc_b, rd_b, ld_b;
    logic [18:0] m_single, b7, b6, b5, ra, rb, rc, l5;
    logic [18:0] sat [6];

    initial begin
        m_single = 19'b0010000_001100_010100;
        b7 = mv(7'b0000001, 6'd8, 6'd16);
        b6 = mv(7'b0000000, 6'd9, 6'd17);
        b5 = mv(7'b0000010, 6'd10, 6'd26);
        ra = mv(7'b0000000, 6'd62, 6'd54);
        rb = mv(7'b0000000, 6'd63, 6'd55);
        rc = mv(7'b0000001, 6'd0, 6'd1);
        l5 = mv(7'b0100000, 6'd5, 6'd21);
        for (int i = 0; i < 6; i++) sat[i] = mv(7'b0, 6'(i), 6'(i + 40));

        // Reset held with start asserted
        reset = 1'b0; start = 1'b1; gen_done = 1'b0; mv_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_rden", 32'(rden), 0);
        check_eq("rst_unit_sel", 32'(unit_sel), 0);
        check_eq("rst_mv_valid", 32'(mv_valid), 0);
        check_eq("rst_mv_data", 32'(mv_data), 0);
        check_eq("rst_move_count", 32'(move_count), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_list_done", 32'(list_done), 0);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check_eq("idle_busy", 32'(busy), 0);

        // Single word from unit 12
        push(6'd12, word8(m_single, INV, INV, INV, INV, INV, INV, INV));
        gen_done = 1'b1; mv_ready = 1'b1;
        acc_b = acc_n; rd_b = rd_n; ld_b = ld_n;
        pulse_start();
        wait_ld(ld_b, "single");
        check_eq("single_reads", 32'(rd_n - rd_b), 1);
        check_eq("single_unit", 32'(rd_log[rd_b]), 12);
        check_eq("single_moves", 32'(acc_n - acc_b), 1);
        check_eq("single_data", 32'(acc_log[acc_b]), 32'(m_single));
        check_eq("single_count", 32'(move_count), 1);
        check_eq("single_ld_pulses", 32'(ld_n - ld_b), 1);
        check_eq("single_busy", 32'(busy), 0);

        // Backpressure on the first of three moves
        push(6'd7, word8(b7, b6, b5, INV, INV, INV, INV, INV));
        mv_ready = 1'b0;
        acc_b = acc_n; ld_b = ld_n;
        pulse_start();
        begin
            int k;
            k = 0;
            while (!mv_valid && k < 100) begin
                @(negedge clk); #2; k++;
            end
        end
        check_eq("bp_valid_seen", 32'(mv_valid), 1);
        repeat (5) begin
            @(negedge clk); #2;
            check_eq("bp_stall_valid", 32'(mv_valid), 1);
            check_eq("bp_stall_data", 32'(mv_data), 32'(b7));
        end
        @(negedge clk);
        mv_ready = 1'b1;
        wait_ld(ld_b, "bp");
        check_eq("bp_moves", 32'(acc_n - acc_b), 3);
        check_eq("bp_first", 32'(acc_log[acc_b]), 32'(b7));
        check_eq("bp_second", 32'(acc_log[acc_b + 1]), 32'(b6));
        check_eq("bp_third", 32'(acc_log[acc_b + 2]), 32'(b5));
        check_eq("bp_count", 32'(move_count), 3);

        // Round-robin wrap: 62 first, then 63 and 0 arrive while stalled
        gen_done = 1'b0; mv_ready = 1'b0;
        push(6'd62, word8(ra, INV, INV, INV, INV, INV, INV, INV));
        acc_b = acc_n; rd_b = rd_n; ld_b = ld_n;
        pulse_start();
        repeat (20) @(negedge clk);
        push(6'd0, word8(rc, INV, INV, INV, INV, INV, INV, INV));
        push(6'd63, word8(rb, INV, INV, INV, INV, INV, INV, INV));
        @(negedge clk);
        mv_ready = 1'b1; gen_done = 1'b1;
        wait_ld(ld_b, "rr");
        check_eq("rr_reads", 32'(rd_n - rd_b), 3);
        check_eq("rr_read0", 32'(rd_log[rd_b]), 62);
        check_eq("rr_read1", 32'(rd_log[rd_b + 1]), 63);
        check_eq("rr_read2", 32'(rd_log[rd_b + 2]), 0);
        check_eq("rr_moves", 32'(acc_n - acc_b), 3);
        check_eq("rr_mv0", 32'(acc_log[acc_b]), 32'(ra));
        check_eq("rr_mv1", 32'(acc_log[acc_b + 1]), 32'(rb));
        check_eq("rr_mv2", 32'(acc_log[acc_b + 2]), 32'(rc));

        // Late gen_done: unit 5 gains a word in the same cycle gen_done rises
        gen_done = 1'b0;
        acc_b = acc_n; rd_b = rd_n; ld_b = ld_n;
        pulse_start();
        repeat (5) @(negedge clk);
        @(negedge clk);
        gen_done = 1'b1;
        pu = 6'd5; pw = word8(l5, INV, INV, INV, INV, INV, INV, INV); preq = 1'b1;
        @(negedge clk);
        preq = 1'b0;
        wait_ld(ld_b, "late");
        repeat (10) @(negedge clk);
        check_eq("late_ld_pulses", 32'(ld_n - ld_b), 1);
        check_eq("late_reads", 32'(rd_n - rd_b), 1);
        check_eq("late_unit", 32'(rd_log[rd_b]), 5);
        check_eq("late_moves", 32'(acc_n - acc_b), 1);
        check_eq("late_data", 32'(acc_log[acc_b]), 32'(l5));

        // Saturation at MAX_MOVES=4 with six valid slots
        push(6'd3, word8(sat[0], sat[1], sat[2], sat[3], sat[4], sat[5], INV, INV));
        acc_b = acc_n; ld_b = ld_n;
        pulse_start();
        wait_ld(ld_b, "sat");
        check_eq("sat_moves", 32'(acc_n - acc_b), 4);
        for (int i = 0; i < 4; i++)
            check_eq("sat_data", 32'(acc_log[acc_b + i]), 32'(sat[i]));
        check_eq("sat_count", 32'(move_count), 4);
        check_eq("sat_overflow", 32'(overflow), 1);
        ld_b = ld_n;
        pulse_start();
        #2;
        check_eq("restart_count", 32'(move_count), 0);
        check_eq("restart_overflow", 32'(overflow), 0);
        wait_ld(ld_b, "restart");
        check_eq("restart_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
